// File: rtl/ps2_move_queue.sv
// ps2_move_queue: decodes PS/2 set-2 scancodes into cube moves (F B L R Top D).
// It also tracks shift (prime) and key-held state, and queues moves in a small FIFO.
// Ports:
//   CLOCK_50, reset (async, active-high)
//   scancode/ps2_rec : byte in, qualified by the strobe
//   flush            : synchronous queue clear
//   move_ready       : consumer handshake
//   move_valid, move_sel, move_prime : head of queue
//   fifo_count       : number of entries
//   overflow         : a move was dropped
module ps2_move_queue #(
    parameter int FIFO_DEPTH = 4,
    parameter int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic [7:0]    scancode,
    input  logic          ps2_rec,
    input  logic          flush,
    input  logic          move_ready,
    output logic          move_valid,
    output logic [2:0]    move_sel,
    output logic          move_prime,
    output logic [CW-1:0] fifo_count,
    output logic          overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          lshift;
    logic          rshift;
    logic [5:0]    held;
    logic [3:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          is_make;
    logic          is_break;
    logic          key_hit;
    logic [2:0]    key_sel;
    logic [5:0]    key_bit;
    logic          push;
    logic          pop;
    logic          full;
    logic          do_push;
    logic          do_ovf;

    // Prefix FSM
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (ps2_rec) begin
            unique case (state)
                IDLE: begin
                    if (scancode == 8'hF0) begin
                        state_next = BRK;
                    end else if (scancode == 8'hE0) begin
                        state_next = EXT;
                    end
                end
                BRK: state_next = IDLE;
                EXT: begin
                    if (scancode == 8'hF0) begin
                        state_next = EXT_BRK;
                    end else if (scancode != 8'hE0) begin
                        state_next = IDLE;
                    end
                end
                EXT_BRK: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Only unprefixed make/break codes reach the key logic; E0 sequences never do.
    assign is_make = ps2_rec && (state == IDLE)
                     && (scancode != 8'hF0) && (scancode != 8'hE0);
    assign is_break = ps2_rec && (state == BRK);

    always_comb begin
        key_hit = 1'b1;
        key_sel = 3'd0;
        case (scancode)
            8'h2B: key_sel = 3'd0;
            8'h32: key_sel = 3'd1;
            8'h4B: key_sel = 3'd2;
            8'h2D: key_sel = 3'd3;
            8'h3C: key_sel = 3'd4;
            8'h23: key_sel = 3'd5;
            default: key_hit = 1'b0;
        endcase
    end

    assign key_bit = 6'd1 << key_sel;

    // A make code for a key that is still held is a typematic repeat.
    // Such a repeat must not enqueue another move.
    assign push = is_make && key_hit && ((held & key_bit) == 6'd0);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            lshift <= 1'b0;
            rshift <= 1'b0;
            held   <= 6'd0;
        end else begin
            if (is_make) begin
                if (scancode == 8'h12) lshift <= 1'b1;
                if (scancode == 8'h59) rshift <= 1'b1;
                if (key_hit) held <= held | key_bit;
            end
            if (is_break) begin
                if (scancode == 8'h12) lshift <= 1'b0;
                if (scancode == 8'h59) rshift <= 1'b0;
                if (key_hit) held <= held & ~key_bit;
            end
        end
    end

    // Move FIFO
    assign move_valid = (fifo_count != '0);
    assign full       = (fifo_count == CW'(FIFO_DEPTH));
    assign pop        = move_valid && move_ready;
    // When the queue is full, a simultaneous pop frees the slot being written.
    assign do_push    = push && !flush && (!full || pop);
    assign do_ovf     = push && !flush && full && !pop;

    always_ff @(posedge CLOCK_50) begin
        if (do_push) begin
            mem[wr_ptr] <= {lshift | rshift, key_sel};
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= do_ovf;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PW'(1);
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                if (do_push && !pop) begin
                    fifo_count <= fifo_count + CW'(1);
                end else if (pop && !do_push) begin
                    fifo_count <= fifo_count - CW'(1);
                end
            end
        end
    end

    assign move_sel   = move_valid ? mem[rd_ptr][2:0] : 3'b110;
    assign move_prime = move_valid ? mem[rd_ptr][3] : 1'b0;

endmodule

// File: tb/tb_ps2_move_queue.sv
// tb_ps2_move_queue: directed vector table, hand-written corner sequences,
// and random byte streams compared against a queue-based reference model.
module tb_ps2_move_queue;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    scancode;
    logic          ps2_rec;
    logic          flush;
    logic          move_ready;
    logic          move_valid;
    logic [2:0]    move_sel;
    logic          move_prime;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    ps2_move_queue #(.FIFO_DEPTH(DEPTH), .CW(CW)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .scancode  (scancode),
        .ps2_rec   (ps2_rec),
        .flush     (flush),
        .move_ready(move_ready),
        .move_valid(move_valid),
        .move_sel  (move_sel),
        .move_prime(move_prime),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: prefix flags, shift flags, held keys, move queue
    logic [7:0] keys [6] = '{8'h2B, 8'h32, 8'h4B, 8'h2D, 8'h3C, 8'h23};
    bit         m_brk, m_ext, m_ls, m_rs, m_ov;
    bit         m_held [6];
    logic [3:0] m_q [$];

    function automatic int kidx(logic [7:0] b);
        for (int i = 0; i < 6; i++) if (keys[i] == b) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_ls = 0; m_rs = 0; m_ov = 0;
        for (int i = 0; i < 6; i++) m_held[i] = 0;
        m_q.delete();
    endtask

    task automatic model_step(input logic [7:0] b, input bit rec, input bit rdy, input bit fl);
        bit cand;
        bit pop;
        logic [3:0] cv;
        int k;
        cand = 0;
        cv = '0;
        pop = (m_q.size() != 0) && rdy;
        k = kidx(b);
        if (rec) begin
            if (!m_brk && !m_ext) begin
                if (b == 8'hF0) m_brk = 1;
                else if (b == 8'hE0) m_ext = 1;
                else begin
                    if (k >= 0 && !m_held[k]) begin
                        cand = 1;
                        cv = {m_ls | m_rs, 3'(k)};
                    end
                    if (k >= 0) m_held[k] = 1;
                    if (b == 8'h12) m_ls = 1;
                    if (b == 8'h59) m_rs = 1;
                end
            end else if (m_brk && !m_ext) begin
                if (k >= 0) m_held[k] = 0;
                if (b == 8'h12) m_ls = 0;
                if (b == 8'h59) m_rs = 0;
                m_brk = 0;
            end else if (m_ext && !m_brk) begin
                if (b == 8'hF0) m_brk = 1;
                else if (b != 8'hE0) m_ext = 0;
            end else begin
                m_brk = 0;
                m_ext = 0;
            end
        end
        m_ov = 0;
        if (fl) begin
            m_q.delete();
        end else if (cand && m_q.size() == DEPTH && !pop) begin
            m_ov = 1;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (cand) m_q.push_back(cv);
        end
    endtask

    task automatic chk(input string name, input bit v, input logic [2:0] s,
                       input bit p, input int c, input bit o);
        logic [7:0] got;
        logic [7:0] exp;
        logic [CW-1:0] cc;
        cc = c[CW-1:0];
        got = {move_valid, move_sel, move_prime, fifo_count, overflow};
        exp = {v, s, p, cc, o};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got v=%b sel=%b p=%b cnt=%0d ov=%b, want v=%b sel=%b p=%b cnt=%0d ov=%b",
                     name, move_valid, move_sel, move_prime, fifo_count, overflow,
                     v, s, p, c, o);
        end
    endtask

    task automatic chk_model(input string name);
        if (m_q.size() != 0) chk(name, 1, m_q[0][2:0], m_q[0][3], m_q.size(), m_ov);
        else chk(name, 0, 3'b110, 0, 0, m_ov);
    endtask

    // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
    task automatic cyc(input logic [7:0] b, input bit rec, input bit rdy, input bit fl);
        scancode = b;
        ps2_rec = rec;
        move_ready = rdy;
        flush = fl;
        model_step(b, rec, rdy, fl);
        @(posedge clk);
        #1;
        ps2_rec = 0;
        move_ready = 0;
        flush = 0;
    endtask

    typedef struct {
        logic [7:0] code;
        bit rec;
        bit rdy;
        bit fl;
        bit v;
        logic [2:0] sel;
        bit p;
        int cnt;
        bit ov;
    } vec_t;

    vec_t vecs [$];

    function automatic void add(logic [7:0] code, bit rec, bit rdy, bit fl,
                                bit v, logic [2:0] sel, bit p, int cnt, bit ov);
        vecs.push_back('{code, rec, rdy, fl, v, sel, p, cnt, ov});
    endfunction

    function automatic void adde(logic [7:0] code, bit rec, bit rdy, bit fl);
        add(code, rec, rdy, fl, 0, 3'b110, 0, 0, 0);
    endfunction

    logic [7:0] pool [10] = '{8'hF0, 8'hE0, 8'h12, 8'h59, 8'h2B,
                              8'h32, 8'h4B, 8'h2D, 8'h3C, 8'h23};

    initial begin
        // basic make / break with consumer ready
        add (8'h2B, 1, 1, 0, 1, 3'd0, 0, 1, 0);
        adde(8'hF0, 1, 1, 0);
        adde(8'h2B, 1, 1, 0);
        // left shift gives prime, then released
        adde(8'h12, 1, 1, 0);
        add (8'h2D, 1, 1, 0, 1, 3'd3, 1, 1, 0);
        adde(8'hF0, 1, 1, 0);
        adde(8'h2D, 1, 1, 0);
        adde(8'hF0, 1, 1, 0);
        adde(8'h12, 1, 1, 0);
        add (8'h2D, 1, 1, 0, 1, 3'd3, 0, 1, 0);
        adde(8'hF0, 1, 1, 0);
        adde(8'h2D, 1, 1, 0);
        // typematic repeat enqueues once
        add (8'h3C, 1, 0, 0, 1, 3'd4, 0, 1, 0);
        add (8'h3C, 1, 0, 0, 1, 3'd4, 0, 1, 0);
        add (8'h3C, 1, 0, 0, 1, 3'd4, 0, 1, 0);
        add (8'hF0, 1, 0, 0, 1, 3'd4, 0, 1, 0);
        add (8'h3C, 1, 0, 0, 1, 3'd4, 0, 1, 0);
        adde(8'h00, 0, 1, 0);
        add (8'h3C, 1, 0, 0, 1, 3'd4, 0, 1, 0);
        adde(8'h00, 0, 1, 0);
        adde(8'hF0, 1, 0, 0);
        adde(8'h3C, 1, 0, 0);
        // E0-prefixed bytes are ignored and never touch shift
        adde(8'hE0, 1, 0, 0);
        adde(8'h12, 1, 0, 0);
        adde(8'hE0, 1, 0, 0);
        adde(8'h4B, 1, 0, 0);
        adde(8'hE0, 1, 0, 0);
        adde(8'hF0, 1, 0, 0);
        adde(8'h4B, 1, 0, 0);
        add (8'h4B, 1, 0, 0, 1, 3'd2, 0, 1, 0);
        adde(8'h00, 0, 1, 0);
        adde(8'hF0, 1, 0, 0);
        adde(8'h4B, 1, 0, 0);
        // flush empties and suppresses same-cycle push
        add (8'h23, 1, 0, 0, 1, 3'd5, 0, 1, 0);
        adde(8'h32, 1, 0, 1);
        adde(8'hF0, 1, 0, 0);
        adde(8'h32, 1, 0, 0);
        adde(8'hF0, 1, 0, 0);
        adde(8'h23, 1, 0, 0);
        // right shift gives prime
        adde(8'h59, 1, 0, 0);
        add (8'h4B, 1, 0, 0, 1, 3'd2, 1, 1, 0);
        adde(8'h00, 0, 1, 0);
        adde(8'hF0, 1, 0, 0);
        adde(8'h59, 1, 0, 0);
        adde(8'hF0, 1, 0, 0);
        adde(8'h4B, 1, 0, 0);

        reset = 1;
        scancode = 0;
        ps2_rec = 0;
        flush = 0;
        move_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        chk("reset_state", 0, 3'b110, 0, 0, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].code, vecs[i].rec, vecs[i].rdy, vecs[i].fl);
            chk($sformatf("vec%0d", i), vecs[i].v, vecs[i].sel, vecs[i].p,
                vecs[i].cnt, vecs[i].ov);
        end

        // fill past capacity: fifth press overflows once
        for (int i = 0; i < 5; i++) begin
            cyc(keys[i], 1, 0, 0);
            chk($sformatf("fill%0d", i), 1, 3'd0, 0, (i < 4) ? i + 1 : 4, i == 4);
        end
        cyc(8'h00, 0, 0, 0);
        chk("ovf_pulse_end", 1, 3'd0, 0, 4, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), 1, 3'(i), 0, 4 - i, 0);
            cyc(8'h00, 0, 1, 0);
        end
        chk("drained", 0, 3'b110, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(8'hF0, 1, 0, 0);
            cyc(keys[i], 1, 0, 0);
        end

        // full queue with push and pop at the same edge
        for (int i = 0; i < 4; i++) cyc(keys[i], 1, 0, 0);
        chk("full", 1, 3'd0, 0, 4, 0);
        cyc(8'h3C, 1, 1, 0);
        chk("full_push_pop", 1, 3'd1, 0, 4, 0);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("wrap%0d", i), 1, 3'(i), 0, 5 - i, 0);
            cyc(8'h00, 0, 1, 0);
        end
        chk("wrap_empty", 0, 3'b110, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(8'hF0, 1, 0, 0);
            cyc(keys[i], 1, 0, 0);
        end

        // reset asserted between F0 and its break byte
        cyc(8'h23, 1, 0, 0);
        chk("pre_reset", 1, 3'd5, 0, 1, 0);
        cyc(8'hF0, 1, 0, 0);
        reset = 1;
        model_reset();
        #1;
        chk("async_reset", 0, 3'b110, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 0;
        cyc(8'h23, 1, 0, 0);
        chk("post_reset_make", 1, 3'd5, 0, 1, 0);
        cyc(8'h00, 0, 1, 0);
        cyc(8'hF0, 1, 0, 0);
        cyc(8'h23, 1, 0, 0);
        chk("post_reset_clean", 0, 3'b110, 0, 0, 0);

        // random byte streams against the model
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] b;
            int pick;
            pick = $urandom_range(0, 11);
            b = (pick < 10) ? pool[pick] : 8'($urandom);
            cyc(b, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                $urandom_range(0, 39) == 0);
            chk_model($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
